// File: rtl/pc_fetch_unit.sv
// Purpose : PC register plus single-outstanding instruction-fetch sequencer feeding decode.
// Latency : grant at N, rvalid at N+1 -> if_valid at N+2; peak one instruction per 3 cycles.
// Backpr. : if_ready low holds if_valid/if_instr/if_pc stable and blocks the next request.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   pc_out / pc_seq_in        - PC to the adder, PC+4 back from the adder
//   redirect_valid/_pc        - taken branch/jump from execute (highest priority)
//   imem_req/_addr/_gnt       - fetch request handshake (addr is always pc_out)
//   imem_rvalid/_rdata        - fetch response
//   if_valid/_ready/_instr/_pc- decode buffer, valid/ready
//   misalign_fault            - misaligned redirect trap flag
//
// Optional feature: FETCH_MISALIGN_TRAP_EN. When defined, a misaligned redirect
// parks the unit in S_FAULT until an aligned redirect or reset. When undefined,
// the low two target bits are cleared and misalign_fault is tied low.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    input  logic [31:0] pc_seq_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign_fault
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_OUT   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        vld_q, vld_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    // Set when the outstanding response belongs to a squashed fetch.
    logic        kill_q, kill_d;
    logic        fault_q, fault_d;
    logic [31:0] redir_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_target = redirect_pc;
`else
    assign redir_target = redirect_pc & ~32'h3;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            vld_q   <= 1'b0;
            instr_q <= 32'h0;
            ipc_q   <= 32'h0;
            kill_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            kill_q  <= kill_d;
            fault_q <= fault_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        vld_d   = vld_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        kill_d  = kill_q;
        fault_d = fault_q;

        if (redirect_valid) begin
            pc_d    = redir_target;
            vld_d   = 1'b0;
            fault_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    // A grant in the redirect cycle still launches the old
                    // address; its response must be squashed.
                    if (imem_gnt) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_d = S_FAULT;
                fault_d = 1'b1;
                kill_d  = 1'b0;
            end
`endif
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_gnt) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            instr_d = imem_rdata;
                            ipc_d   = pc_q;
                            vld_d   = 1'b1;
                            pc_d    = pc_seq_in;
                            state_d = S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (vld_q && if_ready) begin
                        vld_d   = 1'b0;
                        state_d = S_REQ;
                    end
                end
                default: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    state_d = S_FAULT;
`else
                    state_d = S_REQ;
`endif
                end
            endcase
        end
    end

    // Outputs: decoded from registered state; rst only masks the request.
    always_comb begin
        imem_req  = (state_q == S_REQ) && !rst;
        imem_addr = pc_q;
        pc_out    = pc_q;
        if_valid  = vld_q;
        if_instr  = instr_q;
        if_pc     = ipc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_fault = fault_q;
`else
        misalign_fault = 1'b0;
`endif
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_out, pc_seq_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic        misalign_fault;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Stand-in for the PC adder.
    assign pc_seq_in = pc_out + 32'd4;

    pc_fetch_unit #(.RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst),
        .pc_out(pc_out), .pc_seq_in(pc_seq_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc),
        .misalign_fault(misalign_fault)
    );

    typedef struct {
        logic        rst, gnt, rv;
        logic [31:0] rdata;
        logic        rdy, redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc, e_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic add(input logic r, g, rv, input logic [31:0] rd, input logic rdy, rdr,
                       input logic [31:0] rpc, input logic ereq, input logic [31:0] eaddr,
                       input logic evld, input logic [31:0] epc, einstr);
        vec_t v;
        v.rst = r; v.gnt = g; v.rv = rv; v.rdata = rd; v.rdy = rdy; v.redir = rdr; v.rpc = rpc;
        v.e_req = ereq; v.e_addr = eaddr; v.e_vld = evld; v.e_pc = epc; v.e_instr = einstr;
        vecs.push_back(v);
    endtask

    task automatic idle();
        rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    initial begin
        //   rst g rv rdata         rdy rdr rpc     | req addr    vld pc       instr
        add(1, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h100, 0, 32'h0,   32'h0);
        add(1, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h100, 0, 32'h0,   32'h0);
        add(0, 1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h100, 0, 32'h0,   32'h0);
        add(0, 0, 1, 32'hAAAA0100, 0, 0, 32'h0,   0, 32'h100, 0, 32'h0,   32'h0);
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,   0, 32'h104, 1, 32'h100, 32'hAAAA0100);
        add(0, 1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h104, 0, 32'h100, 32'hAAAA0100);
        add(0, 0, 1, 32'hBBBB0104, 0, 0, 32'h0,   0, 32'h104, 0, 32'h100, 32'hAAAA0100);
        for (int i = 0; i < 5; i++)   // back-pressure: five cycles with if_ready low
            add(0, 0, 0, 32'h0,    0, 0, 32'h0,   0, 32'h108, 1, 32'h104, 32'hBBBB0104);
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,   0, 32'h108, 1, 32'h104, 32'hBBBB0104);
        add(0, 1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h108, 0, 32'h104, 32'hBBBB0104);
        add(0, 0, 0, 32'h0,        0, 1, 32'h200, 0, 32'h108, 0, 32'h104, 32'hBBBB0104);
        add(0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h200, 0, 32'h104, 32'hBBBB0104);
        add(0, 0, 1, 32'hDEAD0108, 0, 0, 32'h0,   0, 32'h200, 0, 32'h104, 32'hBBBB0104);
        add(0, 1, 0, 32'h0,        0, 1, 32'h300, 1, 32'h200, 0, 32'h104, 32'hBBBB0104);
        add(0, 0, 1, 32'hDEAD0200, 0, 0, 32'h0,   0, 32'h300, 0, 32'h104, 32'hBBBB0104);
        add(0, 1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h300, 0, 32'h104, 32'hBBBB0104);
        add(0, 0, 1, 32'hCCCC0300, 0, 0, 32'h0,   0, 32'h300, 0, 32'h104, 32'hBBBB0104);
        add(0, 0, 0, 32'h0,        1, 1, 32'h400, 0, 32'h304, 1, 32'h300, 32'hCCCC0300);
        add(0, 1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h400, 0, 32'h300, 32'hCCCC0300);
        add(0, 0, 1, 32'hEEEE0400, 0, 0, 32'h0,   0, 32'h400, 0, 32'h300, 32'hCCCC0300);
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,   0, 32'h404, 1, 32'h400, 32'hEEEE0400);
        add(0, 0, 1, 32'h12345678, 0, 0, 32'h0,   1, 32'h404, 0, 32'h400, 32'hEEEE0400);
        add(0, 0, 0, 32'h0,        0, 1, 32'h402, 1, 32'h404, 0, 32'h400, 32'hEEEE0400);

        idle();
        rst = 1'b1;
        repeat (2) tick();

        foreach (vecs[i]) begin
            rst = vecs[i].rst; imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rv;
            imem_rdata = vecs[i].rdata; if_ready = vecs[i].rdy;
            redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
            #1;
            chk($sformatf("v%0d_req", i),   imem_req,  vecs[i].e_req);
            chk($sformatf("v%0d_addr", i),  imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_vld", i),   if_valid,  vecs[i].e_vld);
            chk($sformatf("v%0d_pc", i),    if_pc,     vecs[i].e_pc);
            chk($sformatf("v%0d_instr", i), if_instr,  vecs[i].e_instr);
            tick();
        end

        // Outcome of the redirect to 0x402.
        idle();
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("flt_set", misalign_fault, 1);
        chk("flt_req", imem_req, 0);
        chk("flt_pc", pc_out, 32'h402);
        imem_gnt = 1'b1;
        if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flt_hold_req", imem_req, 0);
            chk("flt_hold_vld", if_valid, 0);
            chk("flt_hold_flag", misalign_fault, 1);
        end
        imem_gnt = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h500;
        tick();
        redirect_valid = 1'b0;
        chk("flt_clr", misalign_fault, 0);
        chk("flt_exit_req", imem_req, 1);
        chk("flt_exit_addr", imem_addr, 32'h500);
`else
        chk("mis_addr", imem_addr, 32'h400);
        chk("mis_req", imem_req, 1);
        chk("mis_flag", misalign_fault, 0);
`endif

        // Reset while a response is pending; the late response must be ignored.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("rst_pre_wait", imem_req, 0);
        rst = 1'b1;
        #1;
        chk("req_in_rst", imem_req, 0);
        tick();
        rst = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0BAD0;
        #1;
        chk("rst_req", imem_req, 1);
        chk("rst_addr", imem_addr, 32'h100);
        tick();
        imem_rvalid = 1'b0;
        chk("stale_vld", if_valid, 0);
        chk("stale_req", imem_req, 1);

        // Randomised run against a transaction-level model.
        begin
            logic [31:0] exp_pc, tgt, mem_addr, hold_pc, hold_instr;
            logic        mem_out, hold, rv, g, rdr;
            int          mem_cnt, ndeliv;
            idle();
            rst = 1'b1;
            repeat (2) tick();
            rst = 1'b0;
            exp_pc = 32'h100; mem_out = 1'b0; mem_cnt = 0; hold = 1'b0; ndeliv = 0;
            mem_addr = 32'h0; hold_pc = 32'h0; hold_instr = 32'h0;
            for (int c = 0; c < 4000; c++) begin
                if (hold) begin
                    chk("bp_vld", if_valid, 1);
                    chk("bp_pc", if_pc, hold_pc);
                    chk("bp_instr", if_instr, hold_instr);
                    hold = 1'b0;
                end
                rv  = mem_out && (mem_cnt == 0);
                g   = imem_req && !mem_out && ($urandom_range(0, 3) != 0);
                rdr = ($urandom_range(0, 15) == 0);
                tgt = 32'($urandom_range(0, 4095));
`ifdef FETCH_MISALIGN_TRAP_EN
                tgt = tgt & ~32'h3;
`endif
                imem_rvalid = rv;
                imem_rdata  = rv ? memf(mem_addr) : $urandom;
                imem_gnt    = g;
                if_ready    = ($urandom_range(0, 2) != 0);
                redirect_valid = rdr;
                redirect_pc    = tgt;
                #1;
                if (rdr) begin
                    exp_pc = tgt & ~32'h3;
                end else begin
                    if (if_valid && if_ready) begin
                        chk("rnd_pc", if_pc, exp_pc);
                        chk("rnd_instr", if_instr, memf(exp_pc));
                        exp_pc = exp_pc + 32'd4;
                        ndeliv++;
                    end
                    if (imem_req && g) chk("rnd_gnt_addr", imem_addr, exp_pc);
                    if (if_valid && !if_ready) begin
                        hold = 1'b1; hold_pc = if_pc; hold_instr = if_instr;
                    end
                end
                if (rv) mem_out = 1'b0;
                else if (mem_out) mem_cnt--;
                if (imem_req && g) begin
                    mem_out = 1'b1; mem_addr = imem_addr; mem_cnt = $urandom_range(0, 2);
                end
                tick();
            end
            chk("rnd_deliveries", (ndeliv > 100) ? 32'd1 : 32'd0, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
